// File: rtl/bp_be_dcache_pkg.sv
// Shared types for the BE dcache request path: opcodes, packet layout,
// response exception codes and issuer FSM states.
package bp_be_dcache_pkg;

    localparam int unsigned dcache_opcode_width_gp = 4;
    localparam int unsigned page_offset_width_gp   = 12;
    localparam int unsigned data_width_gp          = 64;

    typedef enum logic [3:0] {
        e_dcache_op_lb     = 4'b0000,
        e_dcache_op_lh     = 4'b0001,
        e_dcache_op_lw     = 4'b0010,
        e_dcache_op_ld     = 4'b0011,
        e_dcache_op_lbu    = 4'b0100,
        e_dcache_op_lhu    = 4'b0101,
        e_dcache_op_lwu    = 4'b0110,
        e_dcache_op_lrw    = 4'b0111,
        e_dcache_op_sb     = 4'b1000,
        e_dcache_op_sh     = 4'b1001,
        e_dcache_op_sw     = 4'b1010,
        e_dcache_op_sd     = 4'b1011,
        e_dcache_op_scw    = 4'b1100,
        e_dcache_op_lrd    = 4'b1101,
        e_dcache_op_scd    = 4'b1110,
        e_dcache_op_fencei = 4'b1111
    } bp_be_dcache_opcode_e;

    typedef struct packed {
        bp_be_dcache_opcode_e              opcode;
        logic [page_offset_width_gp-1:0]   page_offset;
        logic [data_width_gp-1:0]          data;
    } bp_be_dcache_pkt_s;

    typedef enum logic [1:0] {
        e_resp_exc_none         = 2'b00,
        e_resp_exc_misaligned   = 2'b01,
        e_resp_exc_illegal      = 2'b10,
        e_resp_exc_replay_limit = 2'b11
    } bp_be_resp_exc_e;

    typedef enum logic [2:0] {
        e_issuer_ready,
        e_issuer_send,
        e_issuer_wait,
        e_issuer_replay,
        e_issuer_resp,
        e_issuer_drain
    } bp_be_issuer_state_e;

endpackage

// File: rtl/bp_be_dcache_issuer_if.sv
// Pipeline request/response and dcache packet/ptag/completion signals of the issuer.
// master = pipeline/dcache environment, slave = issuer.
interface bp_be_dcache_issuer_if
    import bp_be_dcache_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned page_offset_width_p = 12,
    parameter int unsigned data_width_p        = 64
);
    localparam int unsigned pkt_width_lp  = dcache_opcode_width_gp + page_offset_width_p + data_width_p;
    localparam int unsigned ptag_width_lp = vaddr_width_p - page_offset_width_p;

    logic                     req_v_i;
    logic                     req_ready_o;
    logic [2:0]               req_funct3_i;
    logic                     req_store_i;
    logic                     req_lr_i;
    logic                     req_sc_i;
    logic                     req_fencei_i;
    logic [vaddr_width_p-1:0] req_vaddr_i;
    logic [data_width_p-1:0]  req_data_i;

    logic                     dcache_pkt_v_o;
    logic [pkt_width_lp-1:0]  dcache_pkt_o;
    logic                     dcache_ready_i;
    logic                     ptag_v_o;
    logic [ptag_width_lp-1:0] ptag_o;
    logic                     dcache_v_i;
    logic [data_width_p-1:0]  dcache_data_i;
    logic                     dcache_miss_i;

    logic                     flush_i;
    logic                     resp_v_o;
    logic [data_width_p-1:0]  resp_data_o;
    logic [1:0]               resp_exc_o;
    logic                     resp_yumi_i;

    modport master (
        output req_v_i, req_funct3_i, req_store_i, req_lr_i, req_sc_i, req_fencei_i,
               req_vaddr_i, req_data_i, dcache_ready_i, dcache_v_i, dcache_data_i,
               dcache_miss_i, flush_i, resp_yumi_i,
        input  req_ready_o, dcache_pkt_v_o, dcache_pkt_o, ptag_v_o, ptag_o,
               resp_v_o, resp_data_o, resp_exc_o
    );

    modport slave (
        input  req_v_i, req_funct3_i, req_store_i, req_lr_i, req_sc_i, req_fencei_i,
               req_vaddr_i, req_data_i, dcache_ready_i, dcache_v_i, dcache_data_i,
               dcache_miss_i, flush_i, resp_yumi_i,
        output req_ready_o, dcache_pkt_v_o, dcache_pkt_o, ptag_v_o, ptag_o,
               resp_v_o, resp_data_o, resp_exc_o
    );

endinterface

// File: rtl/bp_be_dcache_opcode_encode.sv
// Combinational micro-op decode: funct3 + kind bits + low vaddr bits
// -> dcache opcode plus illegal / misaligned flags.
module bp_be_dcache_opcode_encode
    import bp_be_dcache_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic                 store,
    input  logic                 lr,
    input  logic                 sc,
    input  logic                 fencei,
    input  logic [2:0]           vaddr_low,
    output bp_be_dcache_opcode_e opcode_c,
    output logic                 illegal_c,
    output logic                 misaligned_c
);

    logic [1:0] size;
    logic       is_unsigned;
    logic [3:0] kinds;
    logic       multi_kind;
    logic       low_nonzero;

    always_comb begin
        size        = funct3[1:0];
        is_unsigned = funct3[2];
        kinds       = {store, lr, sc, fencei};
        // clearing the lowest set bit leaves something only if >1 kind is set
        multi_kind  = |(kinds & (kinds - 4'd1));

        if (fencei)     opcode_c = e_dcache_op_fencei;
        else if (lr)    opcode_c = size[0] ? e_dcache_op_lrd : e_dcache_op_lrw;
        else if (sc)    opcode_c = size[0] ? e_dcache_op_scd : e_dcache_op_scw;
        else if (store) opcode_c = bp_be_dcache_opcode_e'({2'b10, size});
        else            opcode_c = bp_be_dcache_opcode_e'({1'b0, is_unsigned, size});

        case (size)
            2'd0:    low_nonzero = 1'b0;
            2'd1:    low_nonzero = vaddr_low[0];
            2'd2:    low_nonzero = |vaddr_low[1:0];
            default: low_nonzero = |vaddr_low[2:0];
        endcase

        misaligned_c = !fencei && low_nonzero;
        illegal_c    = multi_kind
                     || (!fencei && is_unsigned && (size == 2'd3))
                     || ((lr || sc) && !size[1]);
    end

endmodule

// File: rtl/bp_be_dcache_issuer.sv
// Dcache request issuer: encodes BE memory micro-ops, issues packets with a trailing ptag,
// replays on miss and returns one response per accepted op. BP_BE_DCACHE_ISSUER_STATS_EN adds counters.
module bp_be_dcache_issuer
    import bp_be_dcache_pkg::*;
#(
    parameter int unsigned vaddr_width_p       = 39,
    parameter int unsigned page_offset_width_p = 12,
    parameter int unsigned data_width_p        = 64,
    parameter int unsigned max_replay_p        = 15
)(
    input  logic clk_i,
    input  logic reset_i,
    bp_be_dcache_issuer_if.slave bus
`ifdef BP_BE_DCACHE_ISSUER_STATS_EN
    ,
    output logic [31:0] stat_issued_o,
    output logic [31:0] stat_miss_o,
    output logic [31:0] stat_replay_fail_o
`endif
);

    localparam int unsigned ptag_width_lp = vaddr_width_p - page_offset_width_p;
    localparam int unsigned pkt_width_lp  = dcache_opcode_width_gp + page_offset_width_p + data_width_p;
    localparam int unsigned cnt_width_lp  = (max_replay_p < 1) ? 1 : $clog2(max_replay_p + 1);

    bp_be_issuer_state_e       state_q, state_n;
    logic [pkt_width_lp-1:0]   pkt_q, pkt_n;
    logic [ptag_width_lp-1:0]  tag_q, tag_n;
    logic                      ret_data_q, ret_data_n;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_n;
    logic [data_width_p-1:0]   resp_data_q, resp_data_n;
    bp_be_resp_exc_e           resp_exc_q, resp_exc_n;
    logic                      req_ready_q, pkt_v_q, resp_v_q, ptag_v_q;
    logic [ptag_width_lp-1:0]  ptag_q;

    bp_be_dcache_opcode_e      opcode;
    logic                      illegal, misaligned;
    logic                      accept, handshake;

    bp_be_dcache_opcode_encode encode (
        .funct3       (bus.req_funct3_i),
        .store        (bus.req_store_i),
        .lr           (bus.req_lr_i),
        .sc           (bus.req_sc_i),
        .fencei       (bus.req_fencei_i),
        .vaddr_low    (bus.req_vaddr_i[2:0]),
        .opcode_c     (opcode),
        .illegal_c    (illegal),
        .misaligned_c (misaligned)
    );

    assign accept    = (state_q == e_issuer_ready) && bus.req_v_i && !bus.flush_i;
    assign handshake = (state_q == e_issuer_send) && bus.dcache_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= e_issuer_ready;
        else         state_q <= state_n;
    end

    // Next state and the op/response registers that travel with it
    always_comb begin
        state_n     = state_q;
        pkt_n       = pkt_q;
        tag_n       = tag_q;
        ret_data_n  = ret_data_q;
        cnt_n       = cnt_q;
        resp_data_n = resp_data_q;
        resp_exc_n  = resp_exc_q;

        case (state_q)
            e_issuer_ready: if (accept) begin
                tag_n      = bus.req_vaddr_i[vaddr_width_p-1:page_offset_width_p];
                ret_data_n = !(bus.req_store_i || bus.req_fencei_i);
                pkt_n      = {opcode,
                              bus.req_fencei_i ? page_offset_width_p'(0)
                                               : bus.req_vaddr_i[page_offset_width_p-1:0],
                              (bus.req_store_i || bus.req_sc_i) ? bus.req_data_i
                                                                : data_width_p'(0)};
                if (illegal) begin
                    state_n     = e_issuer_resp;
                    resp_exc_n  = e_resp_exc_illegal;
                    resp_data_n = '0;
                end else if (misaligned) begin
                    state_n     = e_issuer_resp;
                    resp_exc_n  = e_resp_exc_misaligned;
                    resp_data_n = '0;
                end else begin
                    state_n = e_issuer_send;
                end
            end
            e_issuer_send: begin
                if (bus.flush_i)             state_n = e_issuer_ready;
                else if (bus.dcache_ready_i) state_n = e_issuer_wait;
            end
            e_issuer_wait: begin
                // a completion coinciding with the flush needs no draining
                if (bus.flush_i) begin
                    state_n = (bus.dcache_v_i || bus.dcache_miss_i) ? e_issuer_ready : e_issuer_drain;
                end else if (bus.dcache_miss_i) begin
                    state_n = e_issuer_replay;
                end else if (bus.dcache_v_i) begin
                    state_n     = e_issuer_resp;
                    resp_exc_n  = e_resp_exc_none;
                    resp_data_n = ret_data_q ? bus.dcache_data_i : data_width_p'(0);
                end
            end
            e_issuer_replay: begin
                if (bus.flush_i) begin
                    state_n = e_issuer_ready;
                end else if (cnt_q == cnt_width_lp'(max_replay_p)) begin
                    state_n     = e_issuer_resp;
                    resp_exc_n  = e_resp_exc_replay_limit;
                    resp_data_n = '0;
                end else if (bus.dcache_ready_i) begin
                    state_n = e_issuer_send;
                    cnt_n   = cnt_q + cnt_width_lp'(1);
                end
            end
            e_issuer_resp: begin
                if (bus.flush_i || bus.resp_yumi_i) state_n = e_issuer_ready;
            end
            e_issuer_drain: begin
                if (bus.dcache_v_i || bus.dcache_miss_i) state_n = e_issuer_ready;
            end
            default: state_n = e_issuer_ready;
        endcase

        if (state_n == e_issuer_ready) cnt_n = '0;
        if (state_n != e_issuer_resp) begin
            resp_data_n = '0;
            resp_exc_n  = e_resp_exc_none;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pkt_q       <= '0;
            tag_q       <= '0;
            ret_data_q  <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_exc_q  <= e_resp_exc_none;
            req_ready_q <= 1'b1;
            pkt_v_q     <= 1'b0;
            resp_v_q    <= 1'b0;
            ptag_v_q    <= 1'b0;
            ptag_q      <= '0;
        end else begin
            pkt_q       <= pkt_n;
            tag_q       <= tag_n;
            ret_data_q  <= ret_data_n;
            cnt_q       <= cnt_n;
            resp_data_q <= resp_data_n;
            resp_exc_q  <= resp_exc_n;
            req_ready_q <= (state_n == e_issuer_ready);
            pkt_v_q     <= (state_n == e_issuer_send);
            resp_v_q    <= (state_n == e_issuer_resp);
            ptag_v_q    <= handshake;
            ptag_q      <= handshake ? tag_q : '0;
        end
    end

    assign bus.req_ready_o    = req_ready_q;
    assign bus.dcache_pkt_v_o = pkt_v_q;
    assign bus.dcache_pkt_o   = pkt_q;
    assign bus.ptag_v_o       = ptag_v_q;
    assign bus.ptag_o         = ptag_q;
    assign bus.resp_v_o       = resp_v_q;
    assign bus.resp_data_o    = resp_data_q;
    assign bus.resp_exc_o     = resp_exc_q;

`ifdef BP_BE_DCACHE_ISSUER_STATS_EN
    logic [31:0] issued_q, miss_q, fail_q;
    logic        miss_seen, replay_fail;

    assign miss_seen   = (state_q == e_issuer_wait) && bus.dcache_miss_i;
    assign replay_fail = (state_q == e_issuer_replay) && (state_n == e_issuer_resp);

    // Saturating event counters
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            issued_q <= '0;
            miss_q   <= '0;
            fail_q   <= '0;
        end else begin
            if (handshake   && (issued_q != '1)) issued_q <= issued_q + 32'd1;
            if (miss_seen   && (miss_q   != '1)) miss_q   <= miss_q   + 32'd1;
            if (replay_fail && (fail_q   != '1)) fail_q   <= fail_q   + 32'd1;
        end
    end

    assign stat_issued_o      = issued_q;
    assign stat_miss_o        = miss_q;
    assign stat_replay_fail_o = fail_q;
`endif

endmodule
